// File: rtl/sd_dat_pkg.sv
// rtl/sd_dat_pkg.sv - shared types and defaults for the SD DAT transfer controller
package sd_dat_pkg;

    localparam int DEF_BLK_WORDS   = 128;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_TIMEOUT_CYC = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_CRC,
        ST_BUSY,
        ST_GAP,
        ST_FIN
    } xfer_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_CRC   = 2'd1,
        ERR_TMO   = 2'd2,
        ERR_ABORT = 2'd3
    } xfer_err_t;

endpackage

// File: rtl/sd_dat_xfer_ctrl_if.sv
// rtl/sd_dat_xfer_ctrl_if.sv - controller <-> DAT datapath / host buffer signals
interface sd_dat_xfer_ctrl_if;

    logic trans_enable;
    logic dat_width_o;
    logic buf_rd_o;
    logic buf_wr_o;
    logic ack_i;
    logic crc_valid_i;
    logic crc_ok_i;
    logic busy_i;
    logic fifo_empty_i;
    logic fifo_full_i;

    modport master (
        output trans_enable, dat_width_o, buf_rd_o, buf_wr_o,
        input  ack_i, crc_valid_i, crc_ok_i, busy_i, fifo_empty_i, fifo_full_i
    );

    modport slave (
        input  trans_enable, dat_width_o, buf_rd_o, buf_wr_o,
        output ack_i, crc_valid_i, crc_ok_i, busy_i, fifo_empty_i, fifo_full_i
    );

endinterface

// File: rtl/sd_dat_timeout.sv
// rtl/sd_dat_timeout.sv - freezable wait counter with expiry flag; built only with SD_DAT_TIMEOUT_EN
`ifdef SD_DAT_TIMEOUT_EN
module sd_dat_timeout #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (count_en && cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A frozen counter sitting at the limit must not fire
    assign expired = count_en && (cnt_q == LAST);

endmodule
`endif

// File: rtl/sd_dat_xfer_ctrl.sv
// rtl/sd_dat_xfer_ctrl.sv - SD DAT single/multi-block sequencer; SD_DAT_TIMEOUT_EN enables wait timeout
module sd_dat_xfer_ctrl
    import sd_dat_pkg::*;
#(
    parameter int BLK_WORDS   = DEF_BLK_WORDS,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               dir,
    input  logic               mode,
    input  logic               dat_width,
    input  logic [9:0]         blk_count_i,
    input  logic               stop,
    sd_dat_xfer_ctrl_if.master dp,
    output logic               blk_done_o,
    output logic               done_o,
    output logic [1:0]         err_o,
    output logic [9:0]         blocks_left_o
);

    localparam int WCW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam int GCW = $clog2(GAP_CYC + 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(BLK_WORDS - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYC - 1);

    xfer_state_t    state_q, state_d;
    xfer_err_t      err_q, err_code;
    logic           err_set;
    logic           dir_q, mode_q, dat_width_q;
    logic [WCW-1:0] word_cnt_q;
    logic [GCW-1:0] gap_cnt_q;
    logic [9:0]     blocks_left_q;
    logic           stall;
    logic           tmo_hit;

    assign stall = dir_q ? dp.fifo_empty_i : dp.fifo_full_i;

`ifdef SD_DAT_TIMEOUT_EN
    logic wait_st, tmo_expired;

    assign wait_st = (state_q == ST_XFER) || (state_q == ST_CRC) || (state_q == ST_BUSY);

    sd_dat_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    ((state_d != state_q) || dp.ack_i || !wait_st),
        .count_en (wait_st && !((state_q == ST_XFER) && stall)),
        .expired  (tmo_expired)
    );

    // A word arriving on the expiry cycle restarts the wait rather than failing it
    assign tmo_hit = tmo_expired && !dp.ack_i;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        err_set         = 1'b0;
        err_code        = ERR_NONE;
        dp.trans_enable = 1'b0;
        dp.buf_rd_o     = 1'b0;
        dp.buf_wr_o     = 1'b0;
        blk_done_o      = 1'b0;
        done_o          = 1'b0;
        // Abort outranks every other event, including a word ack in the same cycle
        if (stop && state_q != ST_IDLE && state_q != ST_FIN) begin
            state_d  = ST_FIN;
            err_set  = 1'b1;
            err_code = ERR_ABORT;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_LOAD;
                ST_LOAD: state_d = (mode_q && blk_count_i == 10'd0) ? ST_FIN : ST_XFER;
                ST_XFER: begin
                    dp.trans_enable = !stall;
                    if (dp.ack_i) begin
                        dp.buf_rd_o = dir_q;
                        dp.buf_wr_o = !dir_q;
                        if (word_cnt_q == WORD_LAST) state_d = ST_CRC;
                    end else if (tmo_hit) begin
                        state_d  = ST_FIN;
                        err_set  = 1'b1;
                        err_code = ERR_TMO;
                    end
                end
                ST_CRC: begin
                    if (dp.crc_valid_i) begin
                        if (dp.crc_ok_i) begin
                            blk_done_o = 1'b1;
                            state_d    = dir_q ? ST_BUSY : ST_GAP;
                        end else begin
                            state_d  = ST_FIN;
                            err_set  = 1'b1;
                            err_code = ERR_CRC;
                        end
                    end else if (tmo_hit) begin
                        state_d  = ST_FIN;
                        err_set  = 1'b1;
                        err_code = ERR_TMO;
                    end
                end
                ST_BUSY: begin
                    if (!dp.busy_i) begin
                        state_d = ST_GAP;
                    end else if (tmo_hit) begin
                        state_d  = ST_FIN;
                        err_set  = 1'b1;
                        err_code = ERR_TMO;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_d = (blocks_left_q == 10'd0) ? ST_FIN : ST_XFER;
                end
                ST_FIN: begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            err_q         <= ERR_NONE;
            dir_q         <= 1'b0;
            mode_q        <= 1'b0;
            dat_width_q   <= 1'b0;
            word_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            blocks_left_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                dir_q       <= dir;
                mode_q      <= mode;
                dat_width_q <= dat_width;
                err_q       <= ERR_NONE;
            end else if (err_set) begin
                err_q <= err_code;
            end
            if (state_q == ST_LOAD) begin
                blocks_left_q <= mode_q ? blk_count_i : 10'd1;
            end else if (blk_done_o && blocks_left_q != 10'd0) begin
                blocks_left_q <= blocks_left_q - 10'd1;
            end
            if (state_q == ST_LOAD || state_q == ST_GAP) begin
                word_cnt_q <= '0;
            end else if (dp.buf_rd_o || dp.buf_wr_o) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 1'b1 : '0;
        end
    end

    assign dp.dat_width_o = dat_width_q;
    assign err_o          = err_q;
    assign blocks_left_o  = blocks_left_q;

endmodule

// File: tb/tb_sd_dat_xfer_ctrl.sv
// tb/tb_sd_dat_xfer_ctrl.sv - directed bench for sd_dat_xfer_ctrl (BLK_WORDS=4, GAP_CYC=2, TIMEOUT_CYC=16)
module tb_sd_dat_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, dir, mode, dat_width, stop;
    logic [9:0] blk_count;
    logic       blk_done, done;
    logic [1:0] err;
    logic [9:0] blocks_left;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_te = 0, n_rd = 0, n_wr = 0, n_blk = 0, n_done = 0, n_empty_te = 0, n_empty_low = 0;

    always #5 clk = ~clk;

    sd_dat_xfer_ctrl_if dp();

    sd_dat_xfer_ctrl #(.BLK_WORDS(4), .GAP_CYC(2), .TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dir           (dir),
        .mode          (mode),
        .dat_width     (dat_width),
        .blk_count_i   (blk_count),
        .stop          (stop),
        .dp            (dp),
        .blk_done_o    (blk_done),
        .done_o        (done),
        .err_o         (err),
        .blocks_left_o (blocks_left)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (dp.trans_enable) n_te++;
            if (dp.buf_rd_o) n_rd++;
            if (dp.buf_wr_o) n_wr++;
            if (blk_done) n_blk++;
            if (done) n_done++;
            if (dp.fifo_empty_i && dp.trans_enable) n_empty_te++;
            if (dp.fifo_empty_i && !dp.trans_enable) n_empty_low++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_xfer(input logic d, input logic m, input logic wd, input logic [9:0] cnt);
        dir = d; mode = m; dat_width = wd; blk_count = cnt;
        start = 1'b1;
        next();
        start = 1'b0;
        next();
    endtask

    // Starts in the first XFER cycle of a block; returns in the cycle after GAP (or after CRC on a bad block)
    task automatic drive_block(input logic d, input logic ok, input int busy_cyc, input int stall_cyc);
        for (int wi = 0; wi < 4; wi++) begin
            if (wi == 2) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    if (d) dp.fifo_empty_i = 1'b1; else dp.fifo_full_i = 1'b1;
                    dp.ack_i = 1'b0;
                    next();
                end
            end
            dp.fifo_empty_i = 1'b0;
            dp.fifo_full_i  = 1'b0;
            dp.ack_i        = 1'b1;
            next();
        end
        dp.ack_i       = 1'b0;
        dp.crc_valid_i = 1'b1;
        dp.crc_ok_i    = ok;
        dp.busy_i      = d & ok;
        next();
        dp.crc_valid_i = 1'b0;
        dp.crc_ok_i    = 1'b0;
        if (ok) begin
            if (d) begin
                for (int b = 0; b < busy_cyc; b++) next();
                dp.busy_i = 1'b0;
                next();
            end
            next();
            next();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; dir = 1'b0; mode = 1'b0; dat_width = 1'b0; stop = 1'b0; blk_count = '0;
        dp.ack_i = 1'b0; dp.crc_valid_i = 1'b0; dp.crc_ok_i = 1'b0; dp.busy_i = 1'b0;
        dp.fifo_empty_i = 1'b0; dp.fifo_full_i = 1'b0;
        next(); next();
        reset = 1'b0;
        #1;
        total++; if (dp.trans_enable !== 1'b0) begin bad++; $display("FAIL reset_te got=%b want=0", dp.trans_enable); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err); end
        total++; if (blocks_left !== 10'd0) begin bad++; $display("FAIL reset_blocks got=%0d want=0", blocks_left); end
        total++; if ({dp.buf_rd_o, dp.buf_wr_o, dp.dat_width_o, blk_done} !== 4'b0) begin
            bad++; $display("FAIL reset_misc got=%b want=0000", {dp.buf_rd_o, dp.buf_wr_o, dp.dat_width_o, blk_done});
        end
    endtask

    task automatic test_single_read();
        int b_wr, b_rd, b_blk, b_te, b_done, t0;
        b_wr = n_wr; b_rd = n_rd; b_blk = n_blk; b_te = n_te; b_done = n_done;
        begin_xfer(1'b0, 1'b0, 1'b1, 10'd5);
        #1;
        total++; if (blocks_left !== 10'd1) begin bad++; $display("FAIL rd_blocks_init got=%0d want=1", blocks_left); end
        total++; if (dp.dat_width_o !== 1'b1) begin bad++; $display("FAIL rd_width got=%b want=1", dp.dat_width_o); end
        t0 = cyc;
        drive_block(1'b0, 1'b1, 0, 0);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rd_done got=%b want=1", done); end
        total++; if (cyc - t0 !== 7) begin bad++; $display("FAIL rd_latency got=%0d want=7", cyc - t0); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL rd_err got=%0d want=0", err); end
        next();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rd_done_pulse got=%b want=0", done); end
        total++; if (n_wr - b_wr !== 4) begin bad++; $display("FAIL rd_buf_wr got=%0d want=4", n_wr - b_wr); end
        total++; if (n_rd - b_rd !== 0) begin bad++; $display("FAIL rd_buf_rd got=%0d want=0", n_rd - b_rd); end
        total++; if (n_blk - b_blk !== 1) begin bad++; $display("FAIL rd_blk_done got=%0d want=1", n_blk - b_blk); end
        total++; if (n_te - b_te !== 4) begin bad++; $display("FAIL rd_te_cycles got=%0d want=4", n_te - b_te); end
        total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL rd_done_count got=%0d want=1", n_done - b_done); end
    endtask

    task automatic test_multi_write();
        int b_rd, b_blk, t0;
        b_rd = n_rd; b_blk = n_blk;
        begin_xfer(1'b1, 1'b1, 1'b0, 10'd3);
        #1;
        total++; if (blocks_left !== 10'd3) begin bad++; $display("FAIL mw_blocks_init got=%0d want=3", blocks_left); end
        t0 = cyc;
        for (int b = 0; b < 3; b++) begin
            drive_block(1'b1, 1'b1, 10, 0);
            #1;
            total++; if (blocks_left !== 10'(2 - b)) begin
                bad++; $display("FAIL mw_blocks_left blk=%0d got=%0d want=%0d", b, blocks_left, 2 - b);
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mw_done got=%b want=1", done); end
        total++; if (cyc - t0 !== 54) begin bad++; $display("FAIL mw_cycles got=%0d want=54", cyc - t0); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL mw_err got=%0d want=0", err); end
        next();
        total++; if (n_blk - b_blk !== 3) begin bad++; $display("FAIL mw_blk_done got=%0d want=3", n_blk - b_blk); end
        total++; if (n_rd - b_rd !== 12) begin bad++; $display("FAIL mw_buf_rd got=%0d want=12", n_rd - b_rd); end
    endtask

    task automatic test_write_stall();
        int b_te, b_et, b_el, t0;
        b_te = n_te; b_et = n_empty_te; b_el = n_empty_low;
        begin_xfer(1'b1, 1'b0, 1'b0, 10'd0);
        t0 = cyc;
        drive_block(1'b1, 1'b1, 2, 5);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL st_done got=%b want=1", done); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL st_err got=%0d want=0", err); end
        total++; if (cyc - t0 !== 15) begin bad++; $display("FAIL st_cycles got=%0d want=15", cyc - t0); end
        next();
        total++; if (n_empty_low - b_el !== 5) begin bad++; $display("FAIL st_te_low got=%0d want=5", n_empty_low - b_el); end
        total++; if (n_empty_te - b_et !== 0) begin bad++; $display("FAIL st_te_while_empty got=%0d want=0", n_empty_te - b_et); end
        total++; if (n_te - b_te !== 4) begin bad++; $display("FAIL st_te_cycles got=%0d want=4", n_te - b_te); end
    endtask

    task automatic test_crc_error();
        int b_blk;
        b_blk = n_blk;
        begin_xfer(1'b0, 1'b1, 1'b0, 10'd3);
        drive_block(1'b0, 1'b1, 0, 0);
        drive_block(1'b0, 1'b0, 0, 0);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL crc_done got=%b want=1", done); end
        total++; if (err !== 2'd1) begin bad++; $display("FAIL crc_err got=%0d want=1", err); end
        total++; if (blocks_left !== 10'd2) begin bad++; $display("FAIL crc_blocks got=%0d want=2", blocks_left); end
        total++; if (n_blk - b_blk !== 1) begin bad++; $display("FAIL crc_blk_done got=%0d want=1", n_blk - b_blk); end
        next();
        total++; if (err !== 2'd1) begin bad++; $display("FAIL crc_err_held got=%0d want=1", err); end
    endtask

    task automatic test_stop_abort();
        int b_wr;
        b_wr = n_wr;
        begin_xfer(1'b0, 1'b0, 1'b0, 10'd0);
        dp.ack_i = 1'b1;
        next();
        stop = 1'b1;
        #1;
        total++; if (dp.buf_wr_o !== 1'b0) begin bad++; $display("FAIL stop_buf_wr got=%b want=0", dp.buf_wr_o); end
        next();
        stop = 1'b0; dp.ack_i = 1'b0;
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stop_done got=%b want=1", done); end
        total++; if (err !== 2'd3) begin bad++; $display("FAIL stop_err got=%0d want=3", err); end
        next();
        total++; if (n_wr - b_wr !== 1) begin bad++; $display("FAIL stop_words got=%0d want=1", n_wr - b_wr); end
        total++; if (err !== 2'd3 || done !== 1'b0) begin bad++; $display("FAIL stop_hold got=err%0d/done%b want=err3/done0", err, done); end
    endtask

    task automatic test_zero_blocks();
        int b_te;
        b_te = n_te;
        begin_xfer(1'b1, 1'b1, 1'b0, 10'd0);
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
        total++; if (err !== 2'd0) begin bad++; $display("FAIL zero_err got=%0d want=0", err); end
        next();
        total++; if (n_te - b_te !== 0) begin bad++; $display("FAIL zero_te got=%0d want=0", n_te - b_te); end
    endtask

    task automatic test_timeout();
        int b_done;
        b_done = n_done;
        begin_xfer(1'b0, 1'b0, 1'b0, 10'd0);
`ifdef SD_DAT_TIMEOUT_EN
        begin
            int hit;
            hit = -1;
            for (int i = 0; i < 40 && hit < 0; i++) begin
                #1;
                if (done === 1'b1) hit = i;
                else next();
            end
            total++; if (hit !== 16) begin bad++; $display("FAIL tmo_cycle got=%0d want=16", hit); end
            total++; if (err !== 2'd2) begin bad++; $display("FAIL tmo_err got=%0d want=2", err); end
            next();
        end
`else
        for (int i = 0; i < 40; i++) next();
        #1;
        total++; if (n_done - b_done !== 0) begin bad++; $display("FAIL notmo_done got=%0d want=0", n_done - b_done); end
        total++; if (dp.trans_enable !== 1'b1) begin bad++; $display("FAIL notmo_te got=%b want=1", dp.trans_enable); end
        stop = 1'b1;
        next();
        stop = 1'b0;
        #1;
        total++; if (done !== 1'b1 || err !== 2'd3) begin bad++; $display("FAIL notmo_stop got=done%b/err%0d want=done1/err3", done, err); end
        next();
`endif
    endtask

    task automatic test_reset_mid();
        int b_done;
        b_done = n_done;
        begin_xfer(1'b0, 1'b1, 1'b1, 10'd5);
        dp.ack_i = 1'b1;
        next(); next();
        dp.ack_i = 1'b0;
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        total++; if (dp.trans_enable !== 1'b0) begin bad++; $display("FAIL rstmid_te got=%b want=0", dp.trans_enable); end
        total++; if (blocks_left !== 10'd0) begin bad++; $display("FAIL rstmid_blocks got=%0d want=0", blocks_left); end
        total++; if (dp.dat_width_o !== 1'b0) begin bad++; $display("FAIL rstmid_width got=%b want=0", dp.dat_width_o); end
        next(); next();
        total++; if (n_done - b_done !== 0) begin bad++; $display("FAIL rstmid_done got=%0d want=0", n_done - b_done); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_multi_write();
        test_write_stall();
        test_crc_error();
        test_stop_abort();
        test_zero_blocks();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
